// File: rtl/biss_c_master_rx_if.sv
// Register-side bus of the BiSS-C master frame sequencer.
// The register/AXI layer takes the master side: it requests frames and reads results.
// The sequencer takes the slave side.
interface biss_c_master_rx_if #(
    parameter int DATA_BITS = 26
);
    logic                 start_i;
    logic                 busy_o;
    logic                 done_o;
    logic [DATA_BITS-1:0] pos_o;
    logic                 nerr_o;
    logic                 nwarn_o;
    logic                 cds_o;
    logic                 err_noack_o;
    logic                 err_crc_o;
    logic                 err_timeout_o;

    modport master (
        output start_i,
        input  busy_o, done_o, pos_o, nerr_o, nwarn_o, cds_o,
        input  err_noack_o, err_crc_o, err_timeout_o
    );

    modport slave (
        input  start_i,
        output busy_o, done_o, pos_o, nerr_o, nwarn_o, cds_o,
        output err_noack_o, err_crc_o, err_timeout_o
    );
endinterface

// File: rtl/biss_c_master_rx.sv
// BiSS-C master frame sequencer.
// Gates the MA clock divider, samples SLO on MA rising edges, decodes
// ACK/Start/CDS, shifts in position plus nE/nW, checks the inverted CRC6,
// waits for the slave timeout and reports one result per frame.
module biss_c_master_rx #(
    parameter int DATA_BITS   = 26,
    parameter int ACK_MAX     = 32,
    parameter int TIMEOUT_MAX = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ma_clk_i,
    input  logic              slo_i,
    output logic              div_en_o,
    output logic              ma_o,
    biss_c_master_rx_if.slave bus
);
    localparam int SH_BITS = DATA_BITS + 2;
    localparam int BCNT_W  = $clog2(DATA_BITS + 3);
    localparam int ACK_W   = $clog2(ACK_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_MAX + 1);

    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(SH_BITS - 1);
    localparam logic [BCNT_W-1:0] LAST_CRC  = BCNT_W'(5);
    localparam logic [ACK_W-1:0]  ACK_LIMIT = ACK_W'(ACK_MAX);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_ACK, S_WAIT_START, S_CDS, S_DATA,
        S_CRC, S_STOP, S_TIMEOUT, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_slo_meta;
    logic                 r_slo_s;
    logic                 r_ma_q;
    logic                 w_rise;
    logic                 w_start_ok;
    logic                 w_crc_ok;
    logic                 w_div_en;
    logic                 w_busy;
    logic                 w_done;
    logic [ACK_W-1:0]     r_ack_cnt;
    logic [BCNT_W-1:0]    r_bit_cnt;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [SH_BITS-1:0]   r_sh;
    logic [5:0]           r_crc;
    logic [5:0]           r_crc_rx;
    logic [DATA_BITS-1:0] r_pos;
    logic                 r_nerr;
    logic                 r_nwarn;
    logic                 r_cds;
    logic                 r_err_noack;
    logic                 r_err_crc;
    logic                 r_err_timeout;

    // One serial step of CRC6 with polynomial x^6+x+1.
    function automatic logic [5:0] crc6Step(input logic [5:0] c, input logic b);
        logic fb;
        fb = c[5] ^ b;
        return {c[4:0], 1'b0} ^ (fb ? 6'b000011 : 6'b000000);
    endfunction

    assign w_rise     = ma_clk_i & ~r_ma_q;
    assign w_start_ok = bus.start_i & r_slo_s;
    assign w_crc_ok   = (~r_crc_rx == r_crc);

    // Resynchronise SLO and keep last MA level for rising-edge detection; both idle high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slo_meta <= 1'b1;
            r_slo_s    <= 1'b1;
            r_ma_q     <= 1'b1;
        end else begin
            r_slo_meta <= slo_i;
            r_slo_s    <= r_slo_meta;
            r_ma_q     <= ma_clk_i;
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; SLO is only looked at on MA rising edges while the divider runs.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_start_ok) w_next = S_WAIT_ACK;
            S_WAIT_ACK:   if (r_ack_cnt == ACK_LIMIT) w_next = S_STOP;
                          else if (w_rise && !r_slo_s) w_next = S_WAIT_START;
            S_WAIT_START: if (r_ack_cnt == ACK_LIMIT) w_next = S_STOP;
                          else if (w_rise && r_slo_s) w_next = S_CDS;
            S_CDS:        if (w_rise) w_next = S_DATA;
            S_DATA:       if (w_rise && r_bit_cnt == LAST_DATA) w_next = S_CRC;
            S_CRC:        if (w_rise && r_bit_cnt == LAST_CRC) w_next = S_STOP;
            S_STOP:       w_next = S_TIMEOUT;
            S_TIMEOUT:    if (r_slo_s || r_tmo_cnt == TMO_LIMIT) w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Divider enable, busy and done follow directly from the state so reset clears them at once.
    always_comb begin
        w_div_en = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_WAIT_ACK, S_WAIT_START, S_CDS, S_DATA, S_CRC: begin
                w_div_en = 1'b1;
                w_busy   = 1'b1;
            end
            S_STOP, S_TIMEOUT: w_busy = 1'b1;
            S_DONE:            w_done = 1'b1;
            default: ;
        endcase
    end

    // Frame datapath: counters, shift registers, CRC and the reported results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_sh          <= '0;
            r_crc         <= '0;
            r_crc_rx      <= '0;
            r_pos         <= '0;
            r_nerr        <= 1'b1;
            r_nwarn       <= 1'b1;
            r_cds         <= 1'b0;
            r_err_noack   <= 1'b0;
            r_err_crc     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_ack_cnt     <= '0;
                        r_err_noack   <= 1'b0;
                        r_err_crc     <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    if (r_ack_cnt == ACK_LIMIT) r_err_noack <= 1'b1;
                    else if (w_rise && r_slo_s) r_ack_cnt <= r_ack_cnt + 1'b1;
                end
                S_WAIT_START: begin
                    if (r_ack_cnt == ACK_LIMIT) r_err_noack <= 1'b1;
                    else if (w_rise && !r_slo_s) r_ack_cnt <= r_ack_cnt + 1'b1;
                end
                S_CDS: begin
                    if (w_rise) begin
                        r_cds     <= r_slo_s;
                        r_bit_cnt <= '0;
                        r_crc     <= '0;
                    end
                end
                S_DATA: begin
                    if (w_rise) begin
                        r_sh      <= {r_sh[SH_BITS-2:0], r_slo_s};
                        r_crc     <= crc6Step(r_crc, r_slo_s);
                        r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                S_CRC: begin
                    if (w_rise) begin
                        r_crc_rx  <= {r_crc_rx[4:0], r_slo_s};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tmo_cnt <= '0;
                    if (!r_err_noack && !w_crc_ok) r_err_crc <= 1'b1;
                end
                S_TIMEOUT: begin
                    if (r_tmo_cnt != TMO_LIMIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (r_slo_s) begin
                        if (!r_err_noack && !r_err_crc) begin
                            r_pos   <= r_sh[SH_BITS-1:2];
                            r_nerr  <= r_sh[1];
                            r_nwarn <= r_sh[0];
                        end
                    end else if (r_tmo_cnt == TMO_LIMIT) begin
                        r_err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_en_o          = w_div_en;
    assign ma_o              = w_div_en ? ma_clk_i : 1'b1;
    assign bus.busy_o        = w_busy;
    assign bus.done_o        = w_done;
    assign bus.pos_o         = r_pos;
    assign bus.nerr_o        = r_nerr;
    assign bus.nwarn_o       = r_nwarn;
    assign bus.cds_o         = r_cds;
    assign bus.err_noack_o   = r_err_noack;
    assign bus.err_crc_o     = r_err_crc;
    assign bus.err_timeout_o = r_err_timeout;
endmodule

// File: doc/biss_c_master_rx.md
Name: biss_c_master_rx

Overview:
- BiSS-C master frame sequencer, directly downstream of the MA clock divider.
- Gates the divider via `div_en_o` and consumes its divided clock `ma_clk_i`.
- Drives the MA line, samples SLO, decodes ACK/Start/CDS, shifts in position and nE/nW, and checks CRC6.
- Handles the slave timeout and reports one result per frame to the register/AXI layer.

Parameters:
- DATA_BITS, 26, position bits (MSB first), range 8..40.
- ACK_MAX, 32, MA rising edges allowed between frame start and the Start bit before no-ack abort.
- TIMEOUT_MAX, 100000, clk_i cycles allowed for SLO to return high after clocking stops.

Ports:
- clk_i  in  1  system clock, same clock as the divider.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle frame request; ignored while busy_o=1.
- ma_clk_i  in  1  divided clock from the divider; idle high when disabled (divider DEFAULT_LEVEL=1).
- slo_i  in  1  SLO line, asynchronous.
- div_en_o  out  1  divider enable.
- ma_o  out  1  MA line = div_en_o ? ma_clk_i : 1.
- busy_o  out  1  high from accepted start_i until done_o.
- done_o  out  1  one-cycle pulse at the end of every frame, including errored frames.
- pos_o  out  DATA_BITS  last good position.
- nerr_o, nwarn_o  out  1 each  last good nE/nW bits (active low as sent).
- cds_o  out  1  CDS bit of the last frame.
- err_noack_o, err_crc_o, err_timeout_o  out  1 each  frame status, valid from done_o.

Behaviour:
- Reset values: div_en_o=0, ma_o=1, busy_o=0, done_o=0, pos_o=0, nerr_o=1, nwarn_o=1, cds_o=0, all err_*=0; FSM in IDLE.
- Reset mid-frame: immediate return to IDLE, divider disabled, no done_o.
- slo_i passes through a 2-FF synchronizer → slo_s.
- Edge detect: ma_q <= ma_clk_i; rise = ma_clk_i & ~ma_q.
- All SLO sampling happens only on rise cycles.
- The synchronizer delay is the only line-delay compensation. The divider period must be ≥6 clk_i cycles.
- FSM states:
  - IDLE: start_i=1 and slo_s=1 → clear err_*, div_en_o=1, busy_o=1, ack_cnt=0 → WAIT_ACK. If start_i=1 and slo_s=0 (slave busy) → request dropped, no done_o.
  - WAIT_ACK: on rise, slo_s=0 → WAIT_START; else ack_cnt++.
  - WAIT_START: on rise, slo_s=1 → CDS; else ack_cnt++.
  - ack_cnt reaching ACK_MAX in WAIT_ACK or WAIT_START → err_noack_o=1 → STOP.
  - CDS: on rise, cds_o<=slo_s; bit_cnt=0; crc=0 → DATA.
  - DATA: on rise, shift slo_s into sh (DATA_BITS+2 bits) and update crc; after DATA_BITS+2 bits → CRC.
  - CRC: on rise, shift slo_s into crc_rx (6 bits); after 6 bits → STOP.
  - STOP: div_en_o=0; tmo_cnt=0 → TIMEOUT.
  - TIMEOUT: tmo_cnt++ each clk_i. slo_s=1 → DONE. tmo_cnt=TIMEOUT_MAX-1 → err_timeout_o=1 → DONE.
  - DONE: done_o=1 for one cycle, busy_o=0 → IDLE. If no error and CRC matches, load pos_o=sh[DATA_BITS+1:2], nerr_o=sh[1], nwarn_o=sh[0]. If CRC mismatches after a full frame, set err_crc_o=1 and leave pos_o/nerr_o/nwarn_o unchanged.
- CRC6, polynomial x^6+x+1, init 0, over position+nE+nW MSB first:
  - fb = crc[5]^bit;
  - crc <= {crc[4:0],1'b0} ^ (fb ? 6'b000011 : 0).
  - Transmitted CRC is inverted: match when ~crc_rx == crc.
- Bit counter width is clog2(DATA_BITS+3). ack_cnt and tmo_cnt saturate and never wrap.
- start_i while busy_o=1 is ignored and not queued. start_i in the same cycle as done_o is ignored.
- err_noack_o frames skip CRC, so err_crc_o=0. Timeout after a no-ack sets both err_noack_o and err_timeout_o.
- err_* hold their value until the next accepted start_i.

Test Plan:
- Good frame, DATA_BITS=26, pos=0x0ABCDEF, nE=1, nW=1, CRC from bench model, ACK after 3 rises, SLO high 50 cycles after STOP → done_o once, pos_o=0x0ABCDEF, nerr_o=1, nwarn_o=1, all err_*=0, exactly 3+1+1+28+6 MA rising edges before ma_o parks high.
- Same frame with 1 CRC bit flipped → err_crc_o=1; pos_o keeps its previous value 0x0ABCDEF; nerr_o/nwarn_o unchanged.
- SLO held high forever → after 32 rises err_noack_o=1, div_en_o=0, done_o; err_crc_o=0.
- SLO held low after CRC, TIMEOUT_MAX=1000 → err_timeout_o=1 exactly 1000 cycles after STOP, then done_o.
- start_i pulsed mid-DATA and in the done_o cycle → no second frame, busy_o profile unchanged. start_i with slo_i=0 in IDLE → no activity.
- rst_i asserted mid-DATA → div_en_o=0, ma_o=1, busy_o=0 immediately, pos_o=0. Next good frame completes normally.
